alu_uart_tx: RTL
================

Name: alu_uart_tx

Overview:
- Serial-side companion to the ALU display path: formats one ALU operation (A, op, B, result, flags) as a 7-byte ASCII line.
- Transmits the line byte-by-byte over the board UART transmit interface (txdata/txclk/txready).
- Sits in top beside the ALU; a start pulse from pushbutton edge logic triggers one line.
- Operands are captured at start, so pb changes mid-frame do not corrupt the line.

Parameters:
- EOL, 8'h0A, terminating byte of each line.
- ACK_TIMEOUT, 255, max hz100 cycles to wait for txready to fall after a txclk pulse; range 1..255.

Ports:
- hz100  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to send a line; ignored unless idle
- a  input  4  operand A
- b  input  4  operand B
- ctl  input  3  ALU op code
- m  input  4  ALU result
- ovf  input  1  ALU overflow flag
- cout  input  1  ALU carry-out flag
- txready  input  1  UART can accept a byte when 1
- txdata  output  8  byte to transmit
- txclk  output  1  one-cycle strobe; UART latches txdata
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse after the last byte is acknowledged
- err  output  1  sticky; set on any ack timeout, cleared on next accepted start

Behaviour:
- Reset values (async, reset_n=0): state IDLE, txdata=8'h00, txclk=0, busy=0, done=0, err=0, byte index=0, timeout counter=0.
- Reset asserted mid-frame aborts immediately. No further txclk is issued, and the partial line is not resumed.
- Start acceptance:
  - In IDLE with start=1: capture a, b, ctl, m, ovf, cout into registers.
  - Same cycle: clear err, set index 0, go to LOAD. busy=1 from the next cycle.
  - start while busy is ignored, with no side effect.
- Frame bytes, in index order 0..6:
  - 0: hex(A)
  - 1: opchar(ctl)
  - 2: hex(B)
  - 3: '=' (8'h3D)
  - 4: hex(M)
  - 5: flag char
  - 6: EOL
- hex(x): values 0-9 map to 8'h30+x; values A-F map to 8'h41+(x-10), uppercase.
- opchar mapping:
  - 000 '+' (2B), 001 '-' (2D), 010 '~' (7E), 011 '&' (26)
  - 100 '|' (7C), 101 '^' (5E), 110 '<' (3C), 111 '>' (3E)
- Flag char: 'V' (56) if ovf; else 'C' (43) if cout; else ' ' (20). ovf takes priority when both are set.
- FSM states: IDLE, LOAD, SEND, ACK, DONE.
  - LOAD: txdata <= byte[index]; go to SEND. One cycle.
  - SEND: wait while txready=0, with txclk=0. When txready=1, register txclk=1 for exactly one cycle; go to ACK with timeout counter cleared.
  - ACK: txclk=0; wait for txready=0.
    - On txready=0: if index=6 go to DONE, else index+1 and go to LOAD.
    - If the counter reaches ACK_TIMEOUT with txready still 1: set err and advance as if acknowledged. Never wedges.
  - DONE: done=1 for one cycle, busy=0 from the following cycle; return to IDLE.
- txdata is stable from LOAD through the end of ACK for each byte and holds its last value in IDLE.
- txclk is never high for two consecutive cycles. It is never high outside SEND→ACK.
- Minimum latency per byte with an ideal UART is 3 cycles (LOAD, SEND, ACK), so a line takes ≥21 cycles plus DONE.

Decomposition:
- Package alu_uart_pkg holds:
  - state enum (IDLE, LOAD, SEND, ACK, DONE)
  - frame length constant FRAME_LEN=7
  - op-character constants for ctl 000..111
  - ASCII constants EQ_CHAR, FLAG_V, FLAG_C, FLAG_NONE
- One combinational sub-module: hex_to_ascii (4-bit in → 8-bit ASCII out), instantiated three times for A, B and M.

Test Plan:
- Reset check: reset_n=0 at any state → txclk=0, txdata=00, busy=0, done=0, err=0 immediately (asynchronous).
- Basic line: a=3, ctl=000, b=4, m=7, ovf=0, cout=0, start pulse, UART model that drops txready one cycle after txclk → txdata sequence 33 2B 34 3D 37 20 0A, seven txclk pulses, then one done pulse and busy=0.
- Flags: a=7, b=1, m=8, ovf=1, cout=1 → bytes 37 2B 31 3D 38 56 0A. With ovf=0, cout=1, a=F, ctl=110, m=E → 46 3C ... 45 43 0A.
- Backpressure/ignored start: txready held 0 for 50 cycles after start → no txclk until txready rises. A second start while busy → exactly 7 bytes sent, and the captured values from the first start are used.
- Timeout: txready stuck at 1 → each byte advances after ACK_TIMEOUT cycles, err=1 at end. The next start clears err.
- Mid-frame reset: reset_n pulsed low during byte 3 → outputs return to reset values. A subsequent start sends a full fresh 7-byte line from index 0.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// ============================================================================
// Module : alu_uart_pkg
// Brief  : Shared types and ASCII constants for the ALU line transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_uart_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    ACK  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int FRAME_LEN = 7;

  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_NOT = 8'h7E;
  localparam logic [7:0] OP_AND = 8'h26;
  localparam logic [7:0] OP_OR  = 8'h7C;
  localparam logic [7:0] OP_XOR = 8'h5E;
  localparam logic [7:0] OP_SHL = 8'h3C;
  localparam logic [7:0] OP_SHR = 8'h3E;

  localparam logic [7:0] EQ_CHAR   = 8'h3D;
  localparam logic [7:0] FLAG_V    = 8'h56;
  localparam logic [7:0] FLAG_C    = 8'h43;
  localparam logic [7:0] FLAG_NONE = 8'h20;

  function automatic logic [7:0] op_char(input logic [2:0] ctl);
    logic [7:0] c;
    case (ctl)
      3'b000:  c = OP_ADD;
      3'b001:  c = OP_SUB;
      3'b010:  c = OP_NOT;
      3'b011:  c = OP_AND;
      3'b100:  c = OP_OR;
      3'b101:  c = OP_XOR;
      3'b110:  c = OP_SHL;
      default: c = OP_SHR;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_uart_tx_hex_to_ascii.sv
// ============================================================================
// Module : hex_to_ascii
// Brief  : One hex nibble to its uppercase ASCII character.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hex_to_ascii (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // 'A' - 10 = 8'h37, so letters share the same add-offset form as digits
  assign o_ascii = (i_nibble < 4'd10) ? (8'h30 + {4'h0, i_nibble})
                                      : (8'h37 + {4'h0, i_nibble});

endmodule

`default_nettype wire

// File: rtl/alu_uart_tx.sv
// ============================================================================
// Module : alu_uart_tx
// Brief  : Formats one ALU operation as a 7-byte ASCII line and sends it
//          byte-by-byte over the txdata/txclk/txready UART handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_uart_tx
  import alu_uart_pkg::*;
#(
  parameter logic [7:0]  EOL         = 8'h0A,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       hz100,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] ctl,
  input  logic [3:0] m,
  input  logic       ovf,
  input  logic       cout,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] c_last_idx = 3'(FRAME_LEN - 1);
  localparam logic [7:0] c_to_last  = 8'(ACK_TIMEOUT - 1);

  state_t     r_state;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic [3:0] r_a, r_b, r_m;
  logic [2:0] r_ctl;
  logic       r_ovf, r_cout;

  logic [7:0] w_hex_a, w_hex_b, w_hex_m;
  logic [7:0] w_flag;
  logic [7:0] w_byte;
  logic       w_acked;

  hex_to_ascii u_hex_a (.i_nibble(r_a), .o_ascii(w_hex_a));
  hex_to_ascii u_hex_b (.i_nibble(r_b), .o_ascii(w_hex_b));
  hex_to_ascii u_hex_m (.i_nibble(r_m), .o_ascii(w_hex_m));

  assign w_flag = r_ovf ? FLAG_V : (r_cout ? FLAG_C : FLAG_NONE);

  always_comb begin
    w_byte = EOL;
    case (r_idx)
      3'd0:    w_byte = w_hex_a;
      3'd1:    w_byte = op_char(r_ctl);
      3'd2:    w_byte = w_hex_b;
      3'd3:    w_byte = EQ_CHAR;
      3'd4:    w_byte = w_hex_m;
      3'd5:    w_byte = w_flag;
      default: w_byte = EOL;
    endcase
  end

  // A stuck-high txready is treated as an ack once the wait budget is spent
  assign w_acked = !txready || (r_cnt >= c_to_last);

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 8'd0;
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_m     <= 4'd0;
      r_ctl   <= 3'd0;
      r_ovf   <= 1'b0;
      r_cout  <= 1'b0;
      txdata  <= 8'h00;
      txclk   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      txclk <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_m     <= m;
            r_ctl   <= ctl;
            r_ovf   <= ovf;
            r_cout  <= cout;
            err     <= 1'b0;
            r_idx   <= 3'd0;
            busy    <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          txdata  <= w_byte;
          r_state <= SEND;
        end
        SEND: begin
          if (txready) begin
            txclk   <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= ACK;
          end
        end
        ACK: begin
          if (w_acked) begin
            if (txready) err <= 1'b1;
            if (r_idx == c_last_idx) begin
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= LOAD;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
